// File: rtl/dacspi_rx_if.sv
// Frame output bundle of the DAC SPI receiver: held frame, valid/ack handshake, status pulses.
// The receiver drives the master modport, the consumer uses the slave modport.
// rd_valid stays high until rd_ack; a new frame overwrites an unacked one.
interface dacspi_rx_if #(
    parameter int DATA_BITS = 12,
    parameter int CFG_BITS  = 4
);
    logic [DATA_BITS-1:0] rd_data;
    logic [CFG_BITS-1:0]  rd_cfg;
    logic                 rd_valid;
    logic                 rd_ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rd_data, rd_cfg, rd_valid, frame_err, overrun, busy,
        input  rd_ack
    );

    modport slave (
        input  rd_data, rd_cfg, rd_valid, frame_err, overrun, busy,
        output rd_ack
    );
endinterface

// File: rtl/dacspi_rx.sv
// Oversampled SPI mode-0 receiver for the DAC command frame (cfg field + data field, MSB first).
// Latency: pin-level cs_n rise to rd_valid is SYNC_STAGES+2 clk cycles.
// No backpressure: an unacked frame is overwritten by the next good one and overrun pulses.
module dacspi_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int CFG_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spi_cs_n,
    input  logic         spi_sclk,
    input  logic         spi_sdin,
    dacspi_rx_if.master  rd
);
    localparam int DATA_BITS = FRAME_BITS - CFG_BITS;
    localparam int CNT_W     = $clog2(FRAME_BITS + 2);
    localparam int SETTLE_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] WAIT_HIGH = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   cs_prev;
    logic                   sclk_prev;

    logic [1:0]             state;
    logic [FRAME_BITS-1:0]  shift;
    logic [CNT_W-1:0]       cnt;
    logic [SETTLE_W-1:0]    settle;
    logic                   done;

    logic cs_s, sclk_s, sdin_s;
    logic sclk_rise, cs_fall, cs_rise;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    assign rd.busy   = (state == SHIFT);

    // Pin synchronisers plus one extra stage on cs_n/sclk for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            sdin_sync <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], spi_sdin};
            cs_prev   <= cs_s;
            sclk_prev <= sclk_s;
        end
    end

    // Frame FSM: deserialise bits while selected, judge the bit count on deselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_HIGH;
            shift         <= '0;
            cnt           <= '0;
            settle        <= '0;
            done          <= 1'b0;
            rd.frame_err  <= 1'b0;
        end else begin
            done         <= 1'b0;
            rd.frame_err <= 1'b0;
            case (state)
                WAIT_HIGH: begin
                    // The synchroniser still holds its preset (deselected) value for
                    // SYNC_STAGES cycles after reset; only trust cs_n once real pin
                    // values have propagated, so a frame in flight is never joined.
                    if (settle != SETTLE_W'(SYNC_STAGES)) begin
                        settle <= settle + 1'b1;
                    end else if (cs_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        cnt   <= '0;
                        shift <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (cnt == CNT_W'(FRAME_BITS)) begin
                            done <= 1'b1;
                        end else begin
                            rd.frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift <= {shift[FRAME_BITS-2:0], sdin_s};
                        // Saturate one past a full frame so long frames never alias to good.
                        if (cnt != CNT_W'(FRAME_BITS + 1)) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_HIGH;
            endcase
        end
    end

    // Output holding register and valid/ack handshake; newest frame wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd.rd_data  <= '0;
            rd.rd_cfg   <= '0;
            rd.rd_valid <= 1'b0;
            rd.overrun  <= 1'b0;
        end else begin
            rd.overrun <= 1'b0;
            if (done) begin
                rd.rd_cfg   <= shift[FRAME_BITS-1 -: CFG_BITS];
                rd.rd_data  <= shift[DATA_BITS-1:0];
                rd.rd_valid <= 1'b1;
                if (rd.rd_valid && !rd.rd_ack) begin
                    rd.overrun <= 1'b1;
                end
            end else if (rd.rd_valid && rd.rd_ack) begin
                rd.rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dacspi_rx.sv
// Bench for dacspi_rx: drives SPI frames from the pin side and scoreboards delivered frames.
// Expected {cfg,data} words are queued at send time and popped on each new frame at the output.
// Status pulses (frame_err, overrun) are counted by a monitor and compared per scenario.
module tb_dacspi_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_n = 1'b1;
    logic sclk = 1'b0;
    logic sdin = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    dacspi_rx_if #(.DATA_BITS(12), .CFG_BITS(4)) rd_if ();

    dacspi_rx #(
        .FRAME_BITS (16),
        .CFG_BITS   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spi_cs_n(cs_n),
        .spi_sclk(sclk),
        .spi_sdin(sdin),
        .rd      (rd_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard new frames and count status pulses, sampled on the falling edge.
    logic        prev_valid = 1'b0;
    logic [15:0] prev_word  = '0;
    logic        prev_err   = 1'b0;
    logic        prev_ov    = 1'b0;
    int err_pulses = 0, err_cycles = 0, ov_pulses = 0, ov_cycles = 0;

    always @(negedge clk) begin
        logic [15:0] word;
        logic [15:0] e;
        word = {rd_if.rd_cfg, rd_if.rd_data};
        if (rd_if.rd_valid && (!prev_valid || word != prev_word)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_frame", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_frame", word, e);
            end
        end
        if (rd_if.frame_err) err_cycles++;
        if (rd_if.frame_err && !prev_err) err_pulses++;
        if (rd_if.overrun) ov_cycles++;
        if (rd_if.overrun && !prev_ov) ov_pulses++;
        prev_valid = rd_if.rd_valid;
        prev_word  = word;
        prev_err   = rd_if.frame_err;
        prev_ov    = rd_if.overrun;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic shift_bits(input logic [31:0] val, input int hi, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            sdin = val[hi - i];
            wait_clk(half);
            sclk = 1'b1;
            wait_clk(half);
            sclk = 1'b0;
        end
    endtask

    // Ends right after cs_n is driven high (at posedge+2), so callers can time the completion.
    task automatic send_frame(input logic [31:0] val, input int nbits, input int half,
                              output logic mid_busy);
        wait_clk(1);
        cs_n = 1'b0;
        wait_clk(half);
        shift_bits(val, nbits - 1, nbits / 2, half);
        mid_busy = rd_if.busy;
        shift_bits(val, nbits - 1 - nbits / 2, nbits - nbits / 2, half);
        wait_clk(half);
        cs_n = 1'b1;
    endtask

    task automatic ack_pulse();
        wait_clk(1);
        rd_if.rd_ack = 1'b1;
        wait_clk(1);
        rd_if.rd_ack = 1'b0;
    endtask

    initial begin
        logic mid_busy;
        logic busy_seen;
        int   lat;
        logic got;
        int   err0, ov0;

        rd_if.rd_ack = 1'b0;

        // Reset state
        wait_clk(4);
        check("rst_rd_data", rd_if.rd_data, 12'h000);
        check("rst_rd_cfg", rd_if.rd_cfg, 4'h0);
        check("rst_rd_valid", rd_if.rd_valid, 1'b0);
        check("rst_frame_err", rd_if.frame_err, 1'b0);
        check("rst_overrun", rd_if.overrun, 1'b0);
        check("rst_busy", rd_if.busy, 1'b0);
        rst = 1'b0;
        wait_clk(6);

        // First frame and cs_n-to-valid latency
        err0 = err_pulses;
        exp_q.push_back(16'h3ABC);
        send_frame(32'h3ABC, 16, 4, mid_busy);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (rd_if.rd_valid) got = 1'b1;
        end
        check("first_latency", lat, 4);
        check("first_busy_mid", mid_busy, 1'b1);
        check("first_cfg", rd_if.rd_cfg, 4'h3);
        check("first_data", rd_if.rd_data, 12'hABC);
        wait_clk(6);
        check("first_busy_after", rd_if.busy, 1'b0);
        check("first_no_err", err_pulses - err0, 0);

        // Ack without completion clears valid and holds the data
        ack_pulse();
        #1;
        check("ack_valid_clr", rd_if.rd_valid, 1'b0);
        check("ack_data_hold", rd_if.rd_data, 12'hABC);

        // Wrong bit counts from a fresh reset
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        err0 = err_pulses;
        send_frame(32'h1234, 15, 4, mid_busy);
        wait_clk(10);
        send_frame(32'h1ABCD, 17, 4, mid_busy);
        wait_clk(10);
        send_frame(32'h0, 0, 4, mid_busy);
        wait_clk(10);
        check("badlen_err_pulses", err_pulses - err0, 3);
        check("badlen_valid", rd_if.rd_valid, 1'b0);
        check("badlen_data", rd_if.rd_data, 12'h000);

        // Overrun: second frame overwrites unacked first
        ov0 = ov_pulses;
        exp_q.push_back(16'h1111);
        send_frame(32'h1111, 16, 4, mid_busy);
        wait_clk(10);
        exp_q.push_back(16'h2222);
        send_frame(32'h2222, 16, 4, mid_busy);
        wait_clk(10);
        check("ovr_pulses", ov_pulses - ov0, 1);
        check("ovr_data", rd_if.rd_data, 12'h222);
        check("ovr_cfg", rd_if.rd_cfg, 4'h2);
        check("ovr_valid", rd_if.rd_valid, 1'b1);

        // Ack in the completion cycle: valid stays high, no overrun
        ack_pulse();
        wait_clk(4);
        exp_q.push_back(16'h4444);
        send_frame(32'h4444, 16, 4, mid_busy);
        wait_clk(10);
        ov0 = ov_pulses;
        exp_q.push_back(16'h5555);
        send_frame(32'h5555, 16, 4, mid_busy);
        repeat (3) @(posedge clk);
        #2;
        rd_if.rd_ack = 1'b1;
        @(posedge clk);
        #1;
        check("coack_valid", rd_if.rd_valid, 1'b1);
        #1;
        rd_if.rd_ack = 1'b0;
        wait_clk(10);
        check("coack_no_overrun", ov_pulses - ov0, 0);
        check("coack_data", rd_if.rd_data, 12'h555);
        check("coack_valid_after", rd_if.rd_valid, 1'b1);

        // Reset in the middle of a frame, released while cs_n is still low
        err0 = err_pulses;
        wait_clk(1);
        cs_n = 1'b0;
        wait_clk(4);
        shift_bits(32'hFFFF, 15, 7, 4);
        rst = 1'b1;
        wait_clk(3);
        check("midrst_valid", rd_if.rd_valid, 1'b0);
        rst = 1'b0;
        wait_clk(4);
        check("midrst_busy", rd_if.busy, 1'b0);
        shift_bits(32'hFFFF, 8, 9, 4);
        wait_clk(4);
        cs_n = 1'b1;
        wait_clk(10);
        check("midrst_no_err", err_pulses - err0, 0);
        check("midrst_no_frame", rd_if.rd_valid, 1'b0);
        exp_q.push_back(16'h0123);
        send_frame(32'h0123, 16, 4, mid_busy);
        wait_clk(10);
        check("midrst_next_data", rd_if.rd_data, 12'h123);
        check("midrst_next_cfg", rd_if.rd_cfg, 4'h0);

        // sclk and jittered sdin activity with cs_n high must be ignored
        err0 = err_pulses;
        busy_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wait_clk(2);
            sclk = ~sclk;
            #($urandom_range(0, 7));
            sdin = 1'($urandom_range(0, 1));
            if (rd_if.busy) busy_seen = 1'b1;
        end
        sclk = 1'b0;
        wait_clk(10);
        check("idle_busy", busy_seen, 1'b0);
        check("idle_no_err", err_pulses - err0, 0);
        check("idle_hold", {rd_if.rd_cfg, rd_if.rd_data}, 16'h0123);

        // Frame at the fastest supported sclk (clk/4)
        exp_q.push_back(16'h8001);
        send_frame(32'h8001, 16, 2, mid_busy);
        wait_clk(10);
        check("fast_cfg", rd_if.rd_cfg, 4'h8);
        check("fast_data", rd_if.rd_data, 12'h001);

        // Final bookkeeping
        check("sb_all_delivered", exp_q.size(), 0);
        check("err_one_cycle", err_cycles, err_pulses);
        check("ovr_one_cycle", ov_cycles, ov_pulses);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
